// File: rtl/clock509_pkg.sv
// rtl/clock509_pkg.sv - shared sequencer encodings and constants for the clock509 divider bank
package clock509_pkg;

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2
  } seq_state_e;

  // Divisors below this value disable a channel.
  localparam int unsigned MIN_DIVISOR = 2;

endpackage

// File: rtl/divider_channel.sv
// rtl/divider_channel.sv - one runtime-programmable integer divider of clock509 with tick and level outputs
module divider_channel
  import clock509_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clock509,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 load_pending,
  input  logic                 sync,
  input  logic [DIV_WIDTH-1:0] shadow,
  output logic                 tick,
  output logic                 level
);

  logic [DIV_WIDTH-1:0] count_q, count_d;
  logic [DIV_WIDTH-1:0] active_q, active_d;
  logic                 pending_q, pending_d;
  logic                 tick_q, tick_d;
  logic                 level_q, level_d;
  logic                 enabled, wrap, take;
  logic [DIV_WIDTH:0]   half;

  assign enabled = active_q >= DIV_WIDTH'(MIN_DIVISOR);
  assign wrap    = count_q == active_q - 1'b1;
  assign take    = pending_q | load_pending;
  assign half    = ({1'b0, active_q} + 1'b1) >> 1;

  always_comb begin
    count_d   = count_q;
    active_d  = active_q;
    pending_d = take;
    tick_d    = run & enabled & (count_q == '0);
    level_d   = run & enabled & ({1'b0, count_q} < half);

    if (!run || !enabled || sync || wrap) count_d = '0;
    else                                  count_d = count_q + 1'b1;

    // A pending shadow value lands at the wrap, immediately when idle, or on sync.
    if ((run && sync) || (take && (!enabled || (run && wrap)))) begin
      active_d  = shadow;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clock509) begin
    if (reset) begin
      count_q   <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      level_q   <= level_d;
    end
  end

  assign tick  = tick_q;
  assign level = level_q;

endmodule

// File: rtl/clock509_divider_bank.sv
// rtl/clock509_divider_bank.sv - PLL reset/lock sequencer driving a bank of programmable clock509 dividers
module clock509_divider_bank
  import clock509_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int DIV_WIDTH    = 8,
  parameter int HOLD_LOG2    = 10,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int RETRY_WIDTH  = 4
) (
  input  logic                          clock509,
  input  logic                          reset,
  input  logic                          pll_locked,
  output logic                          pll_reset,
  input  logic [CHANNELS*DIV_WIDTH-1:0] divisor,
  input  logic                          load,
  input  logic                          sync,
  output logic [CHANNELS-1:0]           tick,
  output logic [CHANNELS-1:0]           level,
  output logic                          ready,
  output logic [RETRY_WIDTH-1:0]        relock_count
);

  localparam int TMO_WIDTH = $clog2(LOCK_TIMEOUT + 1);

  seq_state_e                    state_q, state_d;
  logic                          lock_meta_q, lock_sync_q;
  logic [HOLD_LOG2-1:0]          hold_q, hold_d;
  logic [TMO_WIDTH-1:0]          tmo_q, tmo_d;
  logic [RETRY_WIDTH-1:0]        relock_q, relock_d;
  logic [CHANNELS*DIV_WIDTH-1:0] shadow_q, shadow_d;
  logic [RETRY_WIDTH-1:0]        relock_inc;
  logic                          run;

  assign relock_inc = relock_q + {{(RETRY_WIDTH-1){1'b0}}, ~&relock_q};

  always_comb begin
    state_d  = state_q;
    hold_d   = '0;
    tmo_d    = '0;
    relock_d = relock_q;
    case (state_q)
      ST_HOLD: begin
        hold_d = hold_q + 1'b1;
        if (&hold_q) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_sync_q) begin
          state_d = ST_RUN;
        end else if (tmo_q == TMO_WIDTH'(LOCK_TIMEOUT - 1)) begin
          state_d  = ST_HOLD;
          relock_d = relock_inc;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_sync_q) begin
          state_d  = ST_HOLD;
          relock_d = relock_inc;
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  // Incoming divisors bypass the shadow so load+sync in one cycle takes effect at once.
  assign shadow_d = load ? divisor : shadow_q;

  // Channels stop on the same edge the sequencer leaves RUN.
  assign run = (state_q == ST_RUN) && (state_d == ST_RUN);

  always_ff @(posedge clock509) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      hold_q      <= '0;
      tmo_q       <= '0;
      relock_q    <= '0;
      shadow_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_meta_q <= pll_locked;
      lock_sync_q <= lock_meta_q;
      hold_q      <= hold_d;
      tmo_q       <= tmo_d;
      relock_q    <= relock_d;
      shadow_q    <= shadow_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    divider_channel #(
      .DIV_WIDTH(DIV_WIDTH)
    ) u_chan (
      .clock509    (clock509),
      .reset       (reset),
      .run         (run),
      .load_pending(load),
      .sync        (sync),
      .shadow      (shadow_d[g*DIV_WIDTH +: DIV_WIDTH]),
      .tick        (tick[g]),
      .level       (level[g])
    );
  end

  assign pll_reset    = (state_q == ST_HOLD);
  assign ready        = (state_q == ST_RUN);
  assign relock_count = relock_q;

endmodule

// File: tb/tb_clock509_divider_bank.sv
// tb/tb_clock509_divider_bank.sv - scoreboard bench for the clock509 divider bank
module tb_clock509_divider_bank;

  logic        clock509 = 1'b0;
  logic        reset, pll_locked, pll_reset, load, sync, ready;
  logic [31:0] divisor;
  logic [3:0]  tick, level, relock_count;
  logic [13:0] obs;

  always #5 clock509 = ~clock509;

  clock509_divider_bank dut (
    .clock509    (clock509),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .pll_reset   (pll_reset),
    .divisor     (divisor),
    .load        (load),
    .sync        (sync),
    .tick        (tick),
    .level       (level),
    .ready       (ready),
    .relock_count(relock_count)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [13:0] want;
    logic [13:0] mask;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_d[4];
  int   exp_k[4];

  assign obs = {pll_reset, ready, relock_count, tick, level};

  always @(posedge clock509) cyc <= cyc + 1;

  always @(negedge clock509) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d not checked before cycle %0d", e.name, e.cyc, cyc);
      end else if ((obs & e.mask) !== (e.want & e.mask)) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got {pll_reset,ready,relock,tick,level}=%b required %b (mask %b)",
                 e.name, cyc, obs, e.want, e.mask);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock509);
    #1;
  endtask

  task automatic push(input int c, input string nm, input logic [13:0] w, input logic [13:0] m);
    exp_t x;
    x.cyc  = c;
    x.name = nm;
    x.want = w;
    x.mask = m;
    sb.push_back(x);
  endtask

  task automatic push_status(input int c, input string nm, input logic pr, input logic rdy,
                             input logic [3:0] rl, input logic [3:0] zmask);
    push(c, nm, {pr, rdy, rl, 4'b0000, 4'b0000}, {2'b11, 4'hF, zmask, zmask});
  endtask

  // Channel i shows displayed count exp_k[i] mod exp_d[i]; d<2 means silent.
  task automatic push_run(input int c, input string nm, input logic [3:0] cm, input logic [3:0] rl);
    logic [3:0] t, l;
    int r;
    for (int i = 0; i < 4; i++) begin
      t[i] = 1'b0;
      l[i] = 1'b0;
      if (exp_d[i] >= 2) begin
        r    = exp_k[i] % exp_d[i];
        t[i] = (r == 0);
        l[i] = (r < (exp_d[i] + 1) / 2);
      end
    end
    push(c, nm, {2'b01, rl, t, l}, {2'b11, 4'hF, cm, cm});
  endtask

  initial begin
    int r0, s, ld, p, c, q;
    reset      = 1'b1;
    pll_locked = 1'b1;
    load       = 1'b0;
    sync       = 1'b0;
    divisor    = '0;
    step(3);
    reset = 1'b0;
    r0 = cyc;
    push_status(r0,        "reset_state", 1'b1, 1'b0, 4'd0, 4'hF);
    push_status(r0 + 1023, "hold_last",   1'b1, 1'b0, 4'd0, 4'hF);
    push_status(r0 + 1024, "wait_lock",   1'b0, 1'b0, 4'd0, 4'hF);
    push_status(r0 + 1025, "run_ready",   1'b0, 1'b1, 4'd0, 4'hF);
    step(1030);

    // ch0=4, ch1=5, then phase-align
    divisor = {8'd0, 8'd0, 8'd5, 8'd4};
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(2);
    sync = 1'b1;
    s = cyc;
    exp_d = '{4, 5, 0, 0};
    for (int k = 0; k < 20; k++) begin
      exp_k = '{k, k, 0, 0};
      push_run(s + 2 + k, "sync_pattern", 4'hF, 4'd0);
    end
    step(1);
    sync = 1'b0;

    // ch0 reload to 6 while count is 1
    step(21);
    ld = cyc;
    divisor = {8'd0, 8'd0, 8'd5, 8'd6};
    load = 1'b1;
    for (int t = ld + 1; t <= ld + 3; t++) begin
      exp_d = '{4, 5, 0, 0};
      exp_k = '{t - s - 2, t - s - 2, 0, 0};
      push_run(t, "reload_old", 4'h3, 4'd0);
    end
    for (int m = 0; m < 18; m++) begin
      exp_d = '{6, 5, 0, 0};
      exp_k = '{m, ld + 4 + m - s - 2, 0, 0};
      push_run(ld + 4 + m, "reload_new", 4'h3, 4'd0);
    end
    step(1);
    load = 1'b0;
    step(25);

    // lock loss for 10 cycles
    p = cyc;
    pll_locked = 1'b0;
    push_status(p + 2,    "loss_latency", 1'b0, 1'b1, 4'd0, 4'h0);
    push_status(p + 3,    "loss_hold",    1'b1, 1'b0, 4'd1, 4'hF);
    push_status(p + 500,  "loss_mid",     1'b1, 1'b0, 4'd1, 4'hF);
    push_status(p + 1026, "relock_hold",  1'b1, 1'b0, 4'd1, 4'hF);
    push_status(p + 1027, "relock_wait",  1'b0, 1'b0, 4'd1, 4'hF);
    push_status(p + 1028, "relock_run",   1'b0, 1'b1, 4'd1, 4'hF);
    exp_d = '{6, 5, 0, 0};
    for (int m = 0; m < 12; m++) begin
      exp_k = '{m, m, 0, 0};
      push_run(p + 1029 + m, "resume_kept", 4'hF, 4'd1);
    end
    step(10);
    pll_locked = 1'b1;
    step(1035);

    // ch2 disabled with D=1, then load+sync with D=3
    c = cyc;
    divisor = {8'd0, 8'd1, 8'd5, 8'd6};
    load = 1'b1;
    exp_d = '{0, 0, 1, 0};
    exp_k = '{0, 0, 0, 0};
    for (int t = c + 1; t <= c + 10; t++) push_run(t, "ch2_d1_silent", 4'b0100, 4'd1);
    step(1);
    load = 1'b0;
    step(10);
    c = cyc;
    divisor = {8'd0, 8'd3, 8'd5, 8'd6};
    load = 1'b1;
    sync = 1'b1;
    exp_d = '{6, 5, 3, 0};
    for (int k = 0; k < 15; k++) begin
      exp_k = '{k, k, k, 0};
      push_run(c + 2 + k, "load_sync", 4'hF, 4'd1);
    end
    step(1);
    load = 1'b0;
    sync = 1'b0;
    step(20);

    // lock never returns: timeouts and saturation
    q = cyc;
    pll_locked = 1'b0;
    push_status(q + 3,    "noloc_hold",  1'b1, 1'b0, 4'd2, 4'hF);
    push_status(q + 1026, "noloc_hend",  1'b1, 1'b0, 4'd2, 4'hF);
    push_status(q + 1027, "noloc_wait",  1'b0, 1'b0, 4'd2, 4'hF);
    push_status(q + 5122, "tmo_last",    1'b0, 1'b0, 4'd2, 4'hF);
    push_status(q + 5123, "tmo_retry",   1'b1, 1'b0, 4'd3, 4'hF);
    for (int n = 2; n <= 14; n++) begin
      push_status(q + 3 + 5120 * n, "retry_sat", 1'b1, 1'b0, (2 + n > 15) ? 4'd15 : 4'(2 + n), 4'hF);
    end
    step(5120 * 14 + 10);

    for (int i = 0; i < 100 && sb.size() > 0; i++) step(1);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
